// File: rtl/dm_pkg.sv
// Shared data-memory definitions: access-size encodings, FSM states, default depth.
// ControlUnit imports this package for the DMCtrl encodings.
package dm_pkg;

  localparam int DM_DEPTH_WORDS = 1024;

  typedef enum logic [2:0] {
    DM_B  = 3'b000,
    DM_H  = 3'b001,
    DM_W  = 3'b010,
    DM_BU = 3'b100,
    DM_HU = 3'b101
  } dm_ctrl_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } dm_state_e;

  // Byte accesses never misalign; unlisted codes behave as word accesses.
  function automatic logic dm_misaligned(input logic [2:0] ctrl, input logic [1:0] addr_lo);
    case (ctrl)
      DM_B, DM_BU: return 1'b0;
      DM_H, DM_HU: return addr_lo[0];
      default:     return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Load/store bus between the core datapath (master) and data_memory (slave).
interface data_memory_if;
  logic [31:0] Address;
  logic [31:0] DataWr;
  logic        DMWr;
  logic [2:0]  DMCtrl;
  logic [31:0] DataRd;
  logic        Busy;
  logic        Misaligned;

  modport master (output Address, DataWr, DMWr, DMCtrl,
                  input  DataRd, Busy, Misaligned);
  modport slave  (input  Address, DataWr, DMWr, DMCtrl,
                  output DataRd, Busy, Misaligned);
endinterface

// File: rtl/dm_load_align.sv
// Combinational load path: picks the byte/half out of the addressed word and extends it.
module dm_load_align
  import dm_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_ctrl,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    case (i_ctrl)
      DM_B:    o_data = {{24{w_byte[7]}}, w_byte};
      DM_BU:   o_data = {24'h0, w_byte};
      DM_H:    o_data = {{16{w_half[15]}}, w_half};
      DM_HU:   o_data = {16'h0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Word-organised little-endian data memory with zero-latency reads, byte/half stores
// and a post-reset sweep that zeroes every word before accepting traffic.
module data_memory
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = DM_DEPTH_WORDS
) (
  input  logic          clk,
  input  logic          rst_n,
  data_memory_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  logic [31:0]      r_mem [DEPTH_WORDS];
  dm_state_e        r_state, w_state_nxt;
  logic [IDX_W-1:0] r_clr_idx, w_clr_idx_nxt;
  logic             w_clr_en;

  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_rd_word, w_merged, w_load;
  logic             w_busy, w_mis, w_store_en;
  logic             w_unused;

  // Upper address bits are dropped on purpose so accesses wrap around the array.
  assign w_idx     = bus.Address[IDX_W+1:2];
  assign w_unused  = ^bus.Address[31:IDX_W+2];
  assign w_rd_word = r_mem[w_idx];
  assign w_mis     = dm_misaligned(bus.DMCtrl, bus.Address[1:0]);
  assign w_busy    = !rst_n || (r_state == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_clr_en      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_en      = 1'b1;
        w_clr_idx_nxt = r_clr_idx + 1'b1;
        if (r_clr_idx == LAST_IDX) w_state_nxt = ST_READY;
      end
      default: ;
    endcase
  end

  // Read-modify-write merge of store data into the currently addressed word.
  always_comb begin
    w_merged   = w_rd_word;
    w_store_en = 1'b0;
    if (bus.DMWr && !w_busy && !w_mis) begin
      case (bus.DMCtrl)
        DM_B: begin
          w_store_en = 1'b1;
          w_merged[{bus.Address[1:0], 3'b000} +: 8] = bus.DataWr[7:0];
        end
        DM_H: begin
          w_store_en = 1'b1;
          if (bus.Address[1]) w_merged[31:16] = bus.DataWr[15:0];
          else                w_merged[15:0]  = bus.DataWr[15:0];
        end
        DM_W: begin
          w_store_en = 1'b1;
          w_merged   = bus.DataWr;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_clr_en) r_mem[r_clr_idx] <= '0;
    else if (w_store_en)   r_mem[w_idx]     <= w_merged;
  end

  dm_load_align u_load_align (
    .i_word    (w_rd_word),
    .i_addr_lo (bus.Address[1:0]),
    .i_ctrl    (bus.DMCtrl),
    .o_data    (w_load)
  );

  assign bus.DataRd     = (w_busy || w_mis) ? '0 : w_load;
  assign bus.Busy       = w_busy;
  assign bus.Misaligned = w_mis;

endmodule

// File: tb/tb_data_memory.sv
// Directed-vector bench for data_memory: clear sweep, load/store sizes, merge,
// misalignment, mid-sweep reset and address aliasing.
module tb_data_memory;
  import dm_pkg::*;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  data_memory_if dm();

  data_memory #(.DEPTH_WORDS(DEPTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dm.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic ld(input logic [2:0] c, input logic [31:0] a,
                    output logic [31:0] d, output logic m);
    @(negedge clk);
    dm.DMWr    = 1'b0;
    dm.DMCtrl  = c;
    dm.Address = a;
    #1;
    d = dm.DataRd;
    m = dm.Misaligned;
  endtask

  task automatic st(input logic [2:0] c, input logic [31:0] a, input logic [31:0] data,
                    output logic [31:0] rd, output logic m);
    @(negedge clk);
    dm.DMWr    = 1'b1;
    dm.DMCtrl  = c;
    dm.Address = a;
    dm.DataWr  = data;
    #1;
    rd = dm.DataRd;
    m  = dm.Misaligned;
    @(negedge clk);
    dm.DMWr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    dm.DMWr = 1'b0;
    repeat (2) @(negedge clk);
    dm.DMCtrl  = 3'b010;
    dm.Address = 32'h12;
    #1;
    chk("rst_misaligned", 32'(dm.Misaligned), 32'd1);
    dm.Address = 32'h10;
    #1;
    chk("rst_busy", 32'(dm.Busy), 32'd1);
    chk("rst_datard", dm.DataRd, 32'h0);
    rst_n = 1'b1;
  endtask

  // Counts Busy cycles after reset release; optionally pulses stores near the end.
  task automatic run_sweep(input int stop_at, input bit pulse, output int cnt);
    cnt = 0;
    #1;
    while (dm.Busy && cnt < stop_at) begin
      cnt++;
      if (cnt == 1) chk("busy_datard", dm.DataRd, 32'h0);
      if (pulse && cnt > DEPTH - 10) begin
        dm.DMWr    = 1'b1;
        dm.DMCtrl  = 3'b010;
        dm.Address = 32'((cnt % 8) * 4);
        dm.DataWr  = 32'hBAD0_0000 | 32'(cnt);
      end
      @(negedge clk);
      #1;
    end
    dm.DMWr = 1'b0;
  endtask

  task automatic scan_zero(input string tag);
    logic [31:0] d;
    logic        m;
    int          nz;
    nz = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ld(3'b010, 32'(i * 4), d, m);
      if (d != 32'h0) nz++;
    end
    chk(tag, 32'(nz), 32'd0);
  endtask

  initial begin
    logic [31:0] d, rd;
    logic        m;
    int          cnt;

    dm.Address = '0;
    dm.DataWr  = '0;
    dm.DMWr    = 1'b0;
    dm.DMCtrl  = 3'b010;

    // Power-up reset and first sweep
    do_reset();
    run_sweep(4 * DEPTH, 1'b0, cnt);
    chk("sweep0_len", 32'(cnt), 32'(DEPTH));

    // Preload garbage, then reset from READY and verify full clear
    for (int i = 0; i < 16; i++) st(3'b010, 32'(i * 4), 32'hA500_0000 + 32'(i) * 32'h0101_0101, rd, m);
    st(3'b010, 32'((DEPTH - 1) * 4), 32'hCAFE_F00D, rd, m);
    ld(3'b010, 32'h8, d, m);                  chk("pre_w8", d, 32'hA702_0202);
    ld(3'b010, 32'((DEPTH - 1) * 4), d, m);   chk("pre_last", d, 32'hCAFE_F00D);
    do_reset();
    run_sweep(4 * DEPTH, 1'b0, cnt);
    chk("sweep1_len", 32'(cnt), 32'(DEPTH));
    scan_zero("scan_after_clear");

    // Word store, sized loads
    st(3'b010, 32'h10, 32'hDEAD_BEEF, rd, m);
    ld(3'b010, 32'h10, d, m);  chk("lw_10", d, 32'hDEAD_BEEF);  chk("lw_10_mis", 32'(m), 32'd0);
    ld(3'b000, 32'h13, d, m);  chk("lb_13", d, 32'hFFFF_FFDE);
    ld(3'b100, 32'h13, d, m);  chk("lbu_13", d, 32'h0000_00DE);
    ld(3'b001, 32'h12, d, m);  chk("lh_12", d, 32'hFFFF_DEAD);
    ld(3'b101, 32'h10, d, m);  chk("lhu_10", d, 32'h0000_BEEF);
    ld(3'b000, 32'h10, d, m);  chk("lb_10", d, 32'hFFFF_FFEF);
    ld(3'b100, 32'h11, d, m);  chk("lbu_11", d, 32'h0000_00BE);
    ld(3'b001, 32'h10, d, m);  chk("lh_10", d, 32'hFFFF_BEEF);

    // Byte / half merge and no-op store codes
    st(3'b000, 32'h11, 32'h1234_5678, rd, m);
    ld(3'b010, 32'h10, d, m);  chk("sb_merge", d, 32'hDEAD_78EF);
    ld(3'b000, 32'h11, d, m);  chk("lb_pos", d, 32'h0000_0078);
    st(3'b001, 32'h12, 32'h0000_ABCD, rd, m);
    ld(3'b010, 32'h10, d, m);  chk("sh_merge", d, 32'hABCD_78EF);
    st(3'b100, 32'h10, 32'hFFFF_FFFF, rd, m);
    ld(3'b010, 32'h10, d, m);  chk("st_bu_noop", d, 32'hABCD_78EF);
    st(3'b011, 32'h10, 32'hFFFF_FFFF, rd, m);
    ld(3'b010, 32'h10, d, m);  chk("st_011_noop", d, 32'hABCD_78EF);
    ld(3'b011, 32'h10, d, m);  chk("ld_011_word", d, 32'hABCD_78EF);
    ld(3'b111, 32'h11, d, m);  chk("ld_111_mis", 32'(m), 32'd1);  chk("ld_111_rd", d, 32'h0);

    // Misalignment
    st(3'b010, 32'h20, 32'h5566_7788, rd, m);
    st(3'b010, 32'h22, 32'h9999_9999, rd, m);  chk("sw_22_mis", 32'(m), 32'd1);
    ld(3'b010, 32'h20, d, m);  chk("w20_kept", d, 32'h5566_7788);
    st(3'b001, 32'h23, 32'h0000_FFFF, rd, m);  chk("sh_23_mis", 32'(m), 32'd1);
    ld(3'b010, 32'h20, d, m);  chk("w20_kept2", d, 32'h5566_7788);
    ld(3'b001, 32'h21, d, m);  chk("lh_21_mis", 32'(m), 32'd1);  chk("lh_21_rd", d, 32'h0);
    ld(3'b000, 32'h21, d, m);  chk("lb_21", d, 32'h0000_0077);   chk("lb_21_mis", 32'(m), 32'd0);
    ld(3'b101, 32'h22, d, m);  chk("lhu_22", d, 32'h0000_5566);

    // Aliasing and read-during-write
    st(3'b010, 32'h0, 32'h0000_0077, rd, m);
    st(3'b010, 32'(DEPTH * 4), 32'h0000_0011, rd, m);  chk("wr_cycle_old", rd, 32'h0000_0077);
    ld(3'b010, 32'h0, d, m);          chk("alias_lw0", d, 32'h0000_0011);
    ld(3'b010, 32'hF000_0010, d, m);  chk("alias_high", d, 32'hABCD_78EF);

    // Reset mid-sweep, with store pulses during the restarted sweep
    do_reset();
    run_sweep(100, 1'b0, cnt);
    chk("partial_len", 32'(cnt), 32'd100);
    do_reset();
    run_sweep(4 * DEPTH, 1'b1, cnt);
    chk("restart_len", 32'(cnt), 32'(DEPTH));
    for (int i = 0; i < 8; i++) begin
      ld(3'b010, 32'(i * 4), d, m);
      chk($sformatf("busy_wr_%0d", i), d, 32'h0);
    end
    scan_zero("scan_after_restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
